// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bundle of the writeback arbiter's producer, issue and
//                register-file write signals. The arbiter takes the slave
//                view; the pipeline around it takes the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int XLEN = 64
);
  // single-cycle ALU result (always taken)
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  // load unit result
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  // mul/div unit result
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;
  // issue-stage destination reservation
  logic            iss_valid;
  logic [4:0]      iss_rd;
  // register file write port and status
  logic            reg_write;
  logic [4:0]      write_register;
  logic [XLEN-1:0] write_data;
  logic [31:0]     busy;
  logic            fifo_full;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  md_valid, md_rd, md_data,
    output md_ready,
    input  iss_valid, iss_rd,
    output reg_write, write_register, write_data, busy, fifo_full
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output md_valid, md_rd, md_data,
    input  md_ready,
    output iss_valid, iss_rd,
    input  reg_write, write_register, write_data, busy, fifo_full
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback arbiter and scoreboard. The ALU result is always
//                written the next cycle; load and mul/div results are
//                round-robin accepted into a shared FIFO and drained when the
//                ALU is idle. A 32-bit busy vector tracks pending writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int              c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [4:0]        r_fifo_rd   [DEPTH];
  logic [XLEN-1:0]   r_fifo_data [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  // round-robin pointer: 1 = load wins a tie
  logic r_favour_ld;

  // registered write port and scoreboard
  logic            r_reg_write;
  logic [4:0]      r_write_register;
  logic [XLEN-1:0] r_write_data;
  logic [31:0]     r_busy;

  // combinational helpers
  logic            w_full;
  logic            w_empty;
  logic            w_grant_ld;
  logic            w_grant_md;
  logic            w_ld_ready;
  logic            w_md_ready;
  logic            w_push;
  logic [4:0]      w_push_rd;
  logic [XLEN-1:0] w_push_data;
  logic            w_pop;
  logic            w_out_valid;
  logic [4:0]      w_out_rd;
  logic [XLEN-1:0] w_out_data;
  logic            w_wr_en;
  logic [31:0]     w_busy_next;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // Accept side: a lone valid is granted, a tie goes to the RR favourite.
  // A full FIFO refuses everything even if it pops this cycle, so ready never
  // depends on the drain decision (and therefore never on alu_valid).
  always_comb begin
    w_grant_ld  = 1'b0;
    w_grant_md  = 1'b0;
    if (bus.ld_valid && bus.md_valid) begin
      w_grant_ld = r_favour_ld;
      w_grant_md = ~r_favour_ld;
    end else begin
      w_grant_ld = bus.ld_valid;
      w_grant_md = bus.md_valid;
    end
    w_ld_ready  = ~w_full & w_grant_ld;
    w_md_ready  = ~w_full & w_grant_md;
    w_push      = w_ld_ready | w_md_ready;
    w_push_rd   = w_ld_ready ? bus.ld_rd   : bus.md_rd;
    w_push_data = w_ld_ready ? bus.ld_data : bus.md_data;
  end

  // Drain side: ALU has absolute priority, otherwise pop the FIFO head.
  // The pop reads the pre-push head, so a pushed entry is never bypassed.
  always_comb begin
    w_pop       = 1'b0;
    w_out_valid = 1'b0;
    w_out_rd    = '0;
    w_out_data  = '0;
    if (bus.alu_valid) begin
      w_out_valid = 1'b1;
      w_out_rd    = bus.alu_rd;
      w_out_data  = bus.alu_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_out_valid = 1'b1;
      w_out_rd    = r_fifo_rd[r_rd_ptr];
      w_out_data  = r_fifo_data[r_rd_ptr];
    end
    // x0 results are consumed but never written
    w_wr_en = w_out_valid & (w_out_rd != 5'd0);
  end

  // Scoreboard next value: clear on write, then set on issue so set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_en) begin
      w_busy_next[w_out_rd] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      w_busy_next[bus.iss_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // FIFO payload write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= w_push_rd;
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers, occupancy and round-robin favourite.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_favour_ld <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_favour_ld <= w_md_ready;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered register-file write port; address/data hold when not writing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else begin
      r_reg_write <= w_wr_en;
      if (w_wr_en) begin
        r_write_register <= w_out_rd;
        r_write_data     <= w_out_data;
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign bus.ld_ready       = w_ld_ready;
  assign bus.md_ready       = w_md_ready;
  assign bus.reg_write      = r_reg_write;
  assign bus.write_register = r_write_register;
  assign bus.write_data     = r_write_data;
  assign bus.busy           = r_busy;
  assign bus.fifo_full      = w_full;

endmodule
`default_nettype wire
